alu_operand_sequencer: RTL



---
 rtl/alu_pkg.sv | 33 +++
 rtl/edge_debounce.sv | 71 +++++++
 rtl/alu_operand_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 3-bit board ALU front end: operand/opcode widths,
// the opcode encoding, the operand-sequencer state encoding (also shown on the
// phase LEDs) and the operand bundle handed to the ALU/display stage.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int NBITS_OPND = 3;
    localparam int NBITS_OP   = 2;

    typedef enum logic [NBITS_OP-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    // The encoding is visible on the phase LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_HOLD = 2'b11
    } seq_state_t;

    typedef struct packed {
        logic [NBITS_OPND-1:0] a;
        logic [NBITS_OPND-1:0] b;
        alu_op_t               op;
    } alu_bundle_t;

endpackage

// File: rtl/edge_debounce.sv
// -----------------------------------------------------------------------------
// edge_debounce
// Filters the operator's load switch and produces a one-cycle rise pulse.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN
//   defined   : load must be seen high for DEBOUNCE_CYCLES consecutive samples
//               before the filtered level goes high; the rise fires on the edge
//               that takes the DEBOUNCE_CYCLES-th high sample.
//   undefined : filtered level is load itself; rise on first high after low.
// Ports:
//   clk_2   in  system clock
//   rst_n   in  synchronous active-low reset
//   i_load  in  raw load switch level
//   o_rise  out one-cycle pulse on an accepted rising edge (combinational)
// -----------------------------------------------------------------------------
module edge_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_2,
    input  logic rst_n,
    input  logic i_load,
    output logic o_rise
);

    if (DEBOUNCE_CYCLES < 1) begin : g_invalid_debounce_cycles
        $error("edge_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic w_load_f;
    logic r_load_q;

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Count including the current sample, so the filtered level goes high on
    // the same edge that takes the final required high sample.
    assign w_cnt_next = !i_load          ? '0      :
                        (r_cnt == CNT_MAX) ? CNT_MAX :
                                             r_cnt + CW'(1);
    assign w_load_f   = (w_cnt_next == CNT_MAX);

    // Resets saturated (filtered high) to agree with r_load_q resetting to 1.
    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_cnt <= CNT_MAX;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end
`else
    assign w_load_f = i_load;
`endif

    // r_load_q resets high: a switch held through reset produces no edge
    // until it is released and raised again.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_load_q <= 1'b1;
        end else begin
            r_load_q <= w_load_f;
        end
    end

    assign o_rise = w_load_f & ~r_load_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// -----------------------------------------------------------------------------
// alu_operand_sequencer
// Collects A, B and the opcode from the shared switches (one load-switch
// confirmation each) and offers them as one stable bundle with valid/ready.
// Optional feature macro: ALU_SEQ_DEBOUNCE_EN (load switch debounce, see
// edge_debounce).
// Ports:
//   clk_2      in  system clock (divided board clock)
//   rst_n      in  synchronous active-low reset
//   din        in  switch value for the field currently expected
//   load       in  confirm switch; acts on its (filtered) rising edge
//   cancel     in  synchronous abort, clears everything back to S_A
//   out_ready  in  consumer accepts the bundle (ignored while out_valid=0)
//   a, b, op   out registered bundle fields, frozen while out_valid=1
//   out_valid  out bundle complete and stable
//   phase      out state encoding for the LEDs
// Priority: reset > cancel > handshake > load rise.
// -----------------------------------------------------------------------------
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk_2,
    input  logic                  rst_n,
    input  logic [NBITS_OPND-1:0] din,
    input  logic                  load,
    input  logic                  cancel,
    input  logic                  out_ready,
    output logic [NBITS_OPND-1:0] a,
    output logic [NBITS_OPND-1:0] b,
    output logic [NBITS_OP-1:0]   op,
    output logic                  out_valid,
    output logic [1:0]            phase
);

    logic        w_rise;
    seq_state_t  r_state,  w_state_nxt;
    alu_bundle_t r_bundle, w_bundle_nxt;
    logic        r_valid,  w_valid_nxt;

    edge_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_edge_debounce (
        .clk_2  (clk_2),
        .rst_n  (rst_n),
        .i_load (load),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk_2) begin
        if (!rst_n) begin
            r_state  <= S_A;
            r_bundle <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bundle <= w_bundle_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_bundle_nxt = r_bundle;
        w_valid_nxt  = r_valid;

        if (cancel) begin
            // Abort wins over everything, including a coincident rise.
            w_state_nxt  = S_A;
            w_bundle_nxt = '0;
            w_valid_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_A: if (w_rise) begin
                    w_bundle_nxt.a = din;
                    w_state_nxt    = S_B;
                end
                S_B: if (w_rise) begin
                    w_bundle_nxt.b = din;
                    w_state_nxt    = S_OP;
                end
                S_OP: if (w_rise) begin
                    w_bundle_nxt.op = alu_op_t'(din[NBITS_OP-1:0]);
                    w_valid_nxt     = 1'b1;
                    w_state_nxt     = S_HOLD;
                end
                // Rises are ignored here, including one that coincides with
                // the handshake: it must not pre-load A.
                S_HOLD: if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_A;
                end
                default: begin
                    w_state_nxt  = S_A;
                    w_bundle_nxt = '0;
                    w_valid_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign a         = r_bundle.a;
    assign b         = r_bundle.b;
    assign op        = r_bundle.op;
    assign out_valid = r_valid;
    assign phase     = r_state;

endmodule
